// File: rtl/flux_tag_arbiter_if.sv
// ============================================================================
// flux_tag_arbiter_if
//   Producer-side request bus and tagged-FIFO write port of the flux arbiter.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface flux_tag_arbiter_if #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
);
  logic                       en;
  logic [FLUX-1:0]            req_write;
  logic [FLUX*DATA_WIDTH-1:0] req_data;
  logic [FLUX-1:0]            req_full;
  logic [FLUX-1:0]            fifo_full;
  logic                       out_write;
  logic [WIDTH-1:0]           out_dataout;
  logic [TAG_WIDTH-1:0]       grant_flux;

  modport master (
    output en, req_write, req_data, fifo_full,
    input  req_full, out_write, out_dataout, grant_flux
  );

  modport slave (
    input  en, req_write, req_data, fifo_full,
    output req_full, out_write, out_dataout, grant_flux
  );
endinterface

`default_nettype wire

// File: rtl/flux_tag_arbiter.sv
// ============================================================================
// flux_tag_arbiter
//   Round-robin, quantum-limited scheduler that tags and forwards one buffered
//   word per producer into a shared multi-flux FIFO write port.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module flux_tag_arbiter #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int QUANTUM    = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  flux_tag_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0]     QUANTUM_C = CNT_W'(QUANTUM);
  localparam logic [TAG_WIDTH-1:0] LAST_RST  = TAG_WIDTH'(FLUX - 1);

  logic [FLUX-1:0]                 slot_valid_q, slot_valid_d;
  logic [FLUX-1:0][DATA_WIDTH-1:0] slot_data_q,  slot_data_d;
  logic [TAG_WIDTH-1:0]            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]                burst_cnt_q,  burst_cnt_d;

  logic [FLUX-1:0]      elig;
  logic [FLUX-1:0]      grant;
  logic [FLUX-1:0]      full;
  logic [TAG_WIDTH-1:0] g_idx;
  logic                 found;
  logic                 sticky;
  int                   scan_idx;

  // Grant selection. A zero burst count means nothing has been granted since
  // reset, so the scan (not the sticky path) picks the first winner.
  always_comb begin
    elig     = slot_valid_q & ~bus.fifo_full & {FLUX{bus.en & rst}};
    grant    = '0;
    g_idx    = '0;
    found    = 1'b0;
    sticky   = 1'b0;
    scan_idx = 0;
    if ((burst_cnt_q != '0) && (burst_cnt_q < QUANTUM_C) && elig[last_grant_q]) begin
      sticky = 1'b1;
      found  = 1'b1;
      g_idx  = last_grant_q;
    end else begin
      for (int k = 1; k <= FLUX; k++) begin
        if (!found) begin
          scan_idx = (int'(last_grant_q) + k) % FLUX;
          if (elig[scan_idx]) begin
            found = 1'b1;
            g_idx = TAG_WIDTH'(scan_idx);
          end
        end
      end
    end
    if (found) grant[g_idx] = 1'b1;
    full = slot_valid_q & ~grant;
  end

  assign bus.req_full    = full;
  assign bus.out_write   = found;
  assign bus.out_dataout = found ? {g_idx, slot_data_q[g_idx]} : '0;
  assign bus.grant_flux  = found ? g_idx : '0;

  // A slot drained this edge may be refilled at the same edge.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    for (int i = 0; i < FLUX; i++) begin
      if (bus.req_write[i] && !full[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
    if (found) begin
      if (sticky) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d  = CNT_W'(1);
        last_grant_d = g_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      last_grant_q <= LAST_RST;
      burst_cnt_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

`default_nettype wire
